// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the shared-adder arbiter.
// Optional build macro: ADDER_SHARE_SAT_EN (saturate the sum on carry-out).
package adder_share_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int W_DEF       = 8;
  localparam int MAX_W       = 64;

`ifdef ADDER_SHARE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  // Turns a raw w-bit sum plus its carry into the reported sum: either the
  // plain modulo-2^w value or all-ones when saturation is built in.
  function automatic logic [MAX_W-1:0] fold_sum(input logic [MAX_W-1:0] raw_sum,
                                                input logic             carry,
                                                input int unsigned      w);
    logic [MAX_W-1:0] mask;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    fold_sum = (SAT_EN && carry) ? mask : (raw_sum & mask);
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx
);

  logic           hit;
  logic [IDW-1:0] cand;

  // Scan from ptr upward with wrap; the first hit wins, grant only when enabled.
  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
    if (en && hit) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one W-bit adder among NUM_REQ requesters with round-robin priority.
// The result slot is a single register that can drain and refill in one cycle.
// Optional build macro: ADDER_SHARE_SAT_EN (sum saturates to all-ones on carry).
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int W       = W_DEF,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W-1:0]         rsp_sum,
  output logic                 rsp_carry,
  output logic [IDW-1:0]       rsp_id
);

  slot_e              state_q;
  slot_e              state_d;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               can_accept;
  logic               accept;
  logic [W-1:0]       a_sel;
  logic [W-1:0]       b_sel;
  logic [W:0]         raw;
  logic [W-1:0]       sum_d;

  // Reset blocks any handshake in the cycle it is asserted.
  assign can_accept = !rst && ((state_q == EMPTY) || rsp_ready);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (can_accept),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign rsp_valid = (state_q == FULL);

  assign a_sel = req_a[grant_idx*W +: W];
  assign b_sel = req_b[grant_idx*W +: W];
  assign raw   = {1'b0, a_sel} + {1'b0, b_sel};
  assign sum_d = W'(fold_sum(MAX_W'(raw[W-1:0]), raw[W], W));

  // Slot next-state: an accept always fills, otherwise a drain empties.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = FULL;
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // Slot, pointer and result registers; result fields only move on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      ptr       <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_sum   <= sum_d;
        rsp_carry <= raw[W];
        rsp_id    <= grant_idx;
        ptr       <= IDW'((int'(grant_idx) + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: table of per-cycle vectors plus hand-written
// backpressure and reset sequences, checked through an expected-result queue.
// Honours ADDER_SHARE_SAT_EN when predicting sums.
module tb_adder_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int W       = 8;
  localparam int IDW     = 2;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [W-1:0]         rsp_sum;
  logic                 rsp_carry;
  logic [IDW-1:0]       rsp_id;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        rdy;
    logic [3:0]  grant;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [7:0] sum;
    logic       carry;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[12];
  int   total;
  int   bad;
  logic model_full;

  localparam logic [31:0] STD_A = 32'h03020100;
  localparam logic [31:0] STD_B = 32'h10101010;

  adder_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .W       (W),
    .IDW     (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] a,
                              input logic [31:0] b, input logic r,
                              input logic [3:0] g);
    vec_t t;
    t.valid = v;
    t.a     = a;
    t.b     = b;
    t.rdy   = r;
    t.grant = g;
    return t;
  endfunction

  function automatic int onehot_to_id(input logic [3:0] g);
    int id;
    id = 0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) id = i;
    end
    return id;
  endfunction

  function automatic exp_t predict(input int id, input logic [31:0] a, input logic [31:0] b);
    exp_t       e;
    logic [8:0] s;
    s       = {1'b0, a[id*8 +: 8]} + {1'b0, b[id*8 +: 8]};
    e.id    = 2'(id);
    e.carry = s[8];
    e.sum   = s[7:0];
`ifdef ADDER_SHARE_SAT_EN
    if (s[8]) e.sum = 8'hFF;
`endif
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive after the edge, check combinational grant and
  // slot occupancy mid-cycle, then update the bench's own slot model.
  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [31:0] a,
                               input logic [31:0] b, input logic rdy, input logic [3:0] g,
                               input string tag);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rdy;
    @(negedge clk);
    #1;
    checkOutput({tag, " req_ready"}, 32'(req_ready), 32'(g));
    checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'(model_full));
    if (r) begin
      model_full = 1'b0;
      sb_q.delete();
    end else if (g != 4'b0000) begin
      sb_q.push_back(predict(onehot_to_id(g), a, b));
      model_full = 1'b1;
    end else if (rdy) begin
      model_full = 1'b0;
    end
  endtask

  task automatic checkHeld(input string tag);
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s held: got=empty want=result", tag);
    end else begin
      checkOutput({tag, " held id"},    32'(rsp_id),    32'(sb_q[0].id));
      checkOutput({tag, " held sum"},   32'(rsp_sum),   32'(sb_q[0].sum));
      checkOutput({tag, " held carry"}, 32'(rsp_carry), 32'(sb_q[0].carry));
    end
  endtask

  // Scoreboard consumer: every result handshake pops and compares one entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected result: got=id%0d want=none", rsp_id);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("rsp_id",    32'(rsp_id),    32'(mon_e.id));
        checkOutput("rsp_sum",   32'(rsp_sum),   32'(mon_e.sum));
        checkOutput("rsp_carry", 32'(rsp_carry), 32'(mon_e.carry));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total      = 0;
    bad        = 0;
    model_full = 1'b0;
    rst        = 1'b1;
    req_valid  = 4'b1111;
    req_a      = STD_A;
    req_b      = STD_B;
    rsp_ready  = 1'b1;

    vecs[0]  = mk(4'b1111, STD_A, STD_B, 1'b1, 4'b0001);
    vecs[1]  = mk(4'b1111, STD_A, STD_B, 1'b1, 4'b0010);
    vecs[2]  = mk(4'b1111, STD_A, STD_B, 1'b1, 4'b0100);
    vecs[3]  = mk(4'b1111, STD_A, STD_B, 1'b1, 4'b1000);
    vecs[4]  = mk(4'b1111, STD_A, STD_B, 1'b1, 4'b0001);
    vecs[5]  = mk(4'b1000, STD_A, STD_B, 1'b1, 4'b1000);
    vecs[6]  = mk(4'b1001, STD_A, STD_B, 1'b1, 4'b0001);
    vecs[7]  = mk(4'b0100, 32'h03F00100, 32'h10201010, 1'b1, 4'b0100);
    vecs[8]  = mk(4'b0000, STD_A, STD_B, 1'b1, 4'b0000);
    vecs[9]  = mk(4'b1111, STD_A, STD_B, 1'b1, 4'b1000);
    vecs[10] = mk(4'b0001, 32'h030201FF, 32'h101010FF, 1'b1, 4'b0001);
    vecs[11] = mk(4'b0000, STD_A, STD_B, 1'b1, 4'b0000);

    $display("[TB] reset with all requesters valid");
    applyStimulus(1'b1, 4'b1111, STD_A, STD_B, 1'b1, 4'b0000, "reset0");
    applyStimulus(1'b1, 4'b1111, STD_A, STD_B, 1'b1, 4'b0000, "reset1");
    checkOutput("reset rsp_sum",   32'(rsp_sum),   32'h0);
    checkOutput("reset rsp_carry", 32'(rsp_carry), 32'h0);
    checkOutput("reset rsp_id",    32'(rsp_id),    32'h0);

    $display("[TB] table vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].rdy,
                    vecs[i].grant, $sformatf("vec%0d", i));
    end

    $display("[TB] backpressure");
    applyStimulus(1'b0, 4'b0001, STD_A, STD_B, 1'b0, 4'b0001, "bp load");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b0110, STD_A, STD_B, 1'b0, 4'b0000, $sformatf("bp stall%0d", i));
      checkHeld($sformatf("bp stall%0d", i));
    end
    applyStimulus(1'b0, 4'b0110, STD_A, STD_B, 1'b1, 4'b0010, "bp release");
    applyStimulus(1'b0, 4'b0000, STD_A, STD_B, 1'b1, 4'b0000, "bp drain");

    $display("[TB] reset during stall");
    applyStimulus(1'b0, 4'b0100, STD_A, STD_B, 1'b0, 4'b0100, "rs load");
    applyStimulus(1'b0, 4'b0100, STD_A, STD_B, 1'b0, 4'b0000, "rs stall");
    checkHeld("rs stall");
    applyStimulus(1'b1, 4'b1111, STD_A, STD_B, 1'b1, 4'b0000, "rs reset");
    applyStimulus(1'b0, 4'b1111, STD_A, STD_B, 1'b1, 4'b0001, "rs after");
    checkOutput("rs after rsp_sum", 32'(rsp_sum), 32'h0);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      applyStimulus(1'b0, 4'b0000, STD_A, STD_B, 1'b1, 4'b0000, $sformatf("drain%0d", i));
    end
    checkOutput("scoreboard empty", 32'(sb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
